// File: rtl/id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_pipe
// Purpose  : Decode stage with registered ID/EX output, N-source operand
//            forwarding (enabled by macro ID_FWD_EN) and load-use interlock.
// Revision : 1.0 - initial release
// ============================================================================
module id_pipe #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int NFWD   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid_i,
  output logic                   if_ready_o,
  input  logic [31:0]            pc_i,
  input  logic [31:0]            inst_i,
  output logic                   reg1_read_o,
  output logic                   reg2_read_o,
  output logic [RA_W-1:0]        reg1_addr_o,
  output logic [RA_W-1:0]        reg2_addr_o,
  input  logic [DATA_W-1:0]      reg1_data_i,
  input  logic [DATA_W-1:0]      reg2_data_i,
  input  logic [NFWD-1:0]        fwd_wreg_i,
  input  logic [NFWD*RA_W-1:0]   fwd_wd_i,
  input  logic [NFWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NFWD-1:0]        fwd_isload_i,
  output logic                   ex_valid_o,
  input  logic                   ex_ready_i,
  output logic [7:0]             aluop_o,
  output logic [2:0]             alusel_o,
  output logic [DATA_W-1:0]      reg1_o,
  output logic [DATA_W-1:0]      reg2_o,
  output logic [RA_W-1:0]        wd_o,
  output logic                   wreg_o,
  output logic                   inst_invalid_o,
  output logic [31:0]            stall_cnt_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP = 8'b00000011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign shamt = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm   = inst_i[15:0];

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              dec_wreg;
  logic [RA_W-1:0]   dec_wd;
  logic              dec_invalid;
  logic              rd_en   [2];
  logic [RA_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0] imm_val [2];
  logic [DATA_W-1:0] rf_data [2];
  logic [DATA_W-1:0] opnd    [2];
  logic              port_haz[2];
  logic              hazard;

  always_comb begin
    dec_aluop   = EXE_NOP_OP;
    dec_alusel  = EXE_RES_NOP;
    dec_wreg    = 1'b0;
    dec_wd      = RA_W'(rd);
    dec_invalid = 1'b1;
    rd_en[0]    = 1'b0;
    rd_en[1]    = 1'b0;
    imm_val[0]  = '0;
    imm_val[1]  = '0;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        rd_en[0]    = 1'b1;
        imm_val[1]  = DATA_W'(imm);
        dec_wd      = RA_W'(rt);
        dec_wreg    = 1'b1;
        dec_alusel  = EXE_RES_LOGIC;
        dec_invalid = 1'b0;
        case (op)
          OP_ANDI: dec_aluop = EXE_AND_OP;
          OP_XORI: dec_aluop = EXE_XOR_OP;
          default: dec_aluop = EXE_OR_OP;
        endcase
      end
      OP_LUI: begin
        imm_val[1]  = DATA_W'({imm, 16'h0000});
        dec_wd      = RA_W'(rt);
        dec_wreg    = 1'b1;
        dec_aluop   = EXE_OR_OP;
        dec_alusel  = EXE_RES_LOGIC;
        dec_invalid = 1'b0;
      end
      OP_SPECIAL: begin
        // The all-zero word aliases SLL r0,r0,0; treat it as a true no-op.
        if (inst_i == 32'h0) begin
          dec_invalid = 1'b0;
        end else begin
          case (funct)
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              rd_en[0]    = 1'b1;
              rd_en[1]    = 1'b1;
              dec_wreg    = 1'b1;
              dec_alusel  = EXE_RES_LOGIC;
              dec_invalid = 1'b0;
              case (funct)
                FN_AND:  dec_aluop = EXE_AND_OP;
                FN_OR:   dec_aluop = EXE_OR_OP;
                FN_XOR:  dec_aluop = EXE_XOR_OP;
                default: dec_aluop = EXE_NOR_OP;
              endcase
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              rd_en[1]    = 1'b1;
              imm_val[0]  = DATA_W'(shamt);
              dec_wreg    = 1'b1;
              dec_alusel  = EXE_RES_SHIFT;
              dec_invalid = 1'b0;
              case (funct)
                FN_SLL:  dec_aluop = EXE_SLL_OP;
                FN_SRL:  dec_aluop = EXE_SRL_OP;
                default: dec_aluop = EXE_SRA_OP;
              endcase
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign rd_addr[0] = RA_W'(rs);
  assign rd_addr[1] = RA_W'(rt);
  assign rf_data[0] = reg1_data_i;
  assign rf_data[1] = reg2_data_i;

  assign reg1_read_o = rd_en[0];
  assign reg2_read_o = rd_en[1];
  assign reg1_addr_o = rd_addr[0];
  assign reg2_addr_o = rd_addr[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic use_port;
    logic hit;
`ifdef ID_FWD_EN
    logic              hit_load;
    logic [DATA_W-1:0] hit_data;
`endif

    assign use_port = rd_en[p] && (rd_addr[p] != '0);

    // Scan from the oldest source down so the youngest match wins.
    always_comb begin
      hit = 1'b0;
`ifdef ID_FWD_EN
      hit_load = 1'b0;
      hit_data = '0;
`endif
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (fwd_wreg_i[k] && (fwd_wd_i[k*RA_W +: RA_W] == rd_addr[p])) begin
          hit = 1'b1;
`ifdef ID_FWD_EN
          hit_load = fwd_isload_i[k];
          hit_data = fwd_wdata_i[k*DATA_W +: DATA_W];
`endif
        end
      end
    end

`ifdef ID_FWD_EN
    assign port_haz[p] = use_port && hit && hit_load;
    assign opnd[p]     = !rd_en[p]    ? imm_val[p] :
                         !use_port    ? '0 :
                         hit          ? hit_data : rf_data[p];
`else
    assign port_haz[p] = use_port && hit;
    assign opnd[p]     = !rd_en[p] ? imm_val[p] :
                         !use_port ? '0 : rf_data[p];
`endif
  end

  assign hazard = port_haz[0] || port_haz[1];

`ifdef ID_FWD_EN
  logic unused_inputs;
  assign unused_inputs = ^pc_i;
`else
  logic unused_inputs;
  assign unused_inputs = ^{pc_i, fwd_wdata_i, fwd_isload_i};
`endif

  logic              id_ex_load;
  logic              ex_valid_d,   ex_valid_q;
  logic [7:0]        aluop_d,      aluop_q;
  logic [2:0]        alusel_d,     alusel_q;
  logic [DATA_W-1:0] reg1_d,       reg1_q;
  logic [DATA_W-1:0] reg2_d,       reg2_q;
  logic [RA_W-1:0]   wd_d,         wd_q;
  logic              wreg_d,       wreg_q;
  logic              invalid_d,    invalid_q;
  logic [31:0]       stall_cnt_d,  stall_cnt_q;

  assign id_ex_load = !ex_valid_q || ex_ready_i;
  assign if_ready_o = !rst && !hazard && id_ex_load;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    aluop_d     = aluop_q;
    alusel_d    = alusel_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    invalid_d   = invalid_q;
    stall_cnt_d = stall_cnt_q;
    if (if_valid_i && hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (id_ex_load) begin
      if (if_valid_i && !hazard) begin
        ex_valid_d = 1'b1;
        aluop_d    = dec_aluop;
        alusel_d   = dec_alusel;
        reg1_d     = opnd[0];
        reg2_d     = opnd[1];
        wd_d       = dec_wd;
        wreg_d     = dec_wreg;
        invalid_d  = dec_invalid;
      end else begin
        ex_valid_d = 1'b0;
        aluop_d    = EXE_NOP_OP;
        alusel_d   = EXE_RES_NOP;
        reg1_d     = '0;
        reg2_d     = '0;
        wd_d       = '0;
        wreg_d     = 1'b0;
        invalid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      aluop_q     <= EXE_NOP_OP;
      alusel_q    <= EXE_RES_NOP;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      invalid_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      aluop_q     <= aluop_d;
      alusel_q    <= alusel_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      invalid_q   <= invalid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign aluop_o        = aluop_q;
  assign alusel_o       = alusel_q;
  assign reg1_o         = reg1_q;
  assign reg2_o         = reg2_q;
  assign wd_o           = wd_q;
  assign wreg_o         = wreg_q;
  assign inst_invalid_o = invalid_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_pipe
// Purpose  : Directed self-checking bench for id_pipe (follows ID_FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_wreg_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic [1:0]  fwd_isload_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic        inst_invalid_o;
  logic [31:0] stall_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_ORI  = 32'h342200F0; // ori  r2,r1,0x00F0
  localparam logic [31:0] I_OR   = 32'h00221825; // or   r3,r1,r2
  localparam logic [31:0] I_OR0  = 32'h00021825; // or   r3,r0,r2
  localparam logic [31:0] I_ANDI = 32'h308500FF; // andi r5,r4,0x00FF
  localparam logic [31:0] I_LUI  = 32'h3C06ABCD; // lui  r6,0xABCD
  localparam logic [31:0] I_SLL  = 32'h000238C0; // sll  r7,r2,3
  localparam logic [31:0] I_NOR  = 32'h00224027; // nor  r8,r1,r2
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  id_pipe dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .fwd_isload_i(fwd_isload_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o),
    .inst_invalid_o(inst_invalid_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    fwd_wreg_i   = 2'b00;
    fwd_wd_i     = '0;
    fwd_wdata_i  = '0;
    fwd_isload_i = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid_i = 1'b0; ex_ready_i = 1'b1;
    inst_i = 32'h0; pc_i = 32'h0; reg1_data_i = 32'h0; reg2_data_i = 32'h0;
    clear_fwd();
    tick(); tick();
    n_assert++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h exp 0", ex_valid_o); end
    n_assert++; if (aluop_o !== 8'h00) begin n_fail++; $display("FAIL rst_aluop: got %0h exp 0", aluop_o); end
    n_assert++; if ({wreg_o, inst_invalid_o, reg1_o, reg2_o, wd_o} !== '0) begin n_fail++; $display("FAIL rst_fields: got nonzero wreg=%0h inv=%0h r1=%0h r2=%0h wd=%0h", wreg_o, inst_invalid_o, reg1_o, reg2_o, wd_o); end
    n_assert++; if (stall_cnt_o !== 32'h0) begin n_fail++; $display("FAIL rst_stall: got %0h exp 0", stall_cnt_o); end
    n_assert++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0h exp 0", if_ready_o); end
    rst = 1'b0; #1;
    n_assert++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %0h exp 1", if_ready_o); end
  endtask

  task automatic test_ori();
    clear_fwd();
    if_valid_i = 1'b1; inst_i = I_ORI;
    reg1_data_i = 32'h12340000; reg2_data_i = 32'hDEADBEEF;
    #1;
    n_assert++; if ({reg1_read_o, reg2_read_o, reg1_addr_o} !== {1'b1, 1'b0, 5'd1}) begin n_fail++; $display("FAIL ori_read: got %0b/%0b/%0d exp 1/0/1", reg1_read_o, reg2_read_o, reg1_addr_o); end
    tick();
    n_assert++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL ori_valid: got %0h exp 1", ex_valid_o); end
    n_assert++; if (reg1_o !== 32'h12340000) begin n_fail++; $display("FAIL ori_reg1: got %h exp 12340000", reg1_o); end
    n_assert++; if (reg2_o !== 32'h000000F0) begin n_fail++; $display("FAIL ori_reg2: got %h exp 000000f0", reg2_o); end
    n_assert++; if ({wd_o, wreg_o, alusel_o, aluop_o} !== {5'd2, 1'b1, 3'd1, 8'h25}) begin n_fail++; $display("FAIL ori_ctrl: got wd=%0d wreg=%0h sel=%0h op=%0h exp 2/1/1/25", wd_o, wreg_o, alusel_o, aluop_o); end
  endtask

  task automatic test_back_to_back();
    clear_fwd();
    reg1_data_i = 32'h0F0F0000; reg2_data_i = 32'h000000F1;
    if_valid_i = 1'b1; inst_i = I_LUI;
    tick();
    n_assert++; if ({reg1_o, reg2_o} !== {32'h0, 32'hABCD0000}) begin n_fail++; $display("FAIL lui_ops: got %h %h exp 0 abcd0000", reg1_o, reg2_o); end
    n_assert++; if ({wd_o, wreg_o, alusel_o, aluop_o} !== {5'd6, 1'b1, 3'd1, 8'h25}) begin n_fail++; $display("FAIL lui_ctrl: got wd=%0d wreg=%0h sel=%0h op=%0h", wd_o, wreg_o, alusel_o, aluop_o); end
    inst_i = I_SLL;
    tick();
    n_assert++; if ({reg1_o, reg2_o} !== {32'h3, 32'h000000F1}) begin n_fail++; $display("FAIL sll_ops: got %h %h exp 3 f1", reg1_o, reg2_o); end
    n_assert++; if ({wd_o, wreg_o, alusel_o, aluop_o} !== {5'd7, 1'b1, 3'd2, 8'h7C}) begin n_fail++; $display("FAIL sll_ctrl: got wd=%0d wreg=%0h sel=%0h op=%0h", wd_o, wreg_o, alusel_o, aluop_o); end
    inst_i = I_NOR;
    tick();
    n_assert++; if ({reg1_o, reg2_o} !== {32'h0F0F0000, 32'h000000F1}) begin n_fail++; $display("FAIL nor_ops: got %h %h", reg1_o, reg2_o); end
    n_assert++; if ({wd_o, wreg_o, aluop_o} !== {5'd8, 1'b1, 8'h27}) begin n_fail++; $display("FAIL nor_ctrl: got wd=%0d wreg=%0h op=%0h", wd_o, wreg_o, aluop_o); end
    inst_i = 32'h0;
    tick();
    n_assert++; if ({ex_valid_o, wreg_o, inst_invalid_o, aluop_o} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin n_fail++; $display("FAIL nop: got v=%0h wreg=%0h inv=%0h op=%0h exp 1/0/0/0", ex_valid_o, wreg_o, inst_invalid_o, aluop_o); end
  endtask

  task automatic test_fwd_priority();
    reg1_data_i = 32'h11111111; reg2_data_i = 32'h22222222;
    if_valid_i = 1'b1; inst_i = I_OR;
    fwd_wreg_i = 2'b11; fwd_isload_i = 2'b00;
    fwd_wd_i = {5'd1, 5'd1};
    fwd_wdata_i = {32'h0000000B, 32'h0000000A};
    #1;
`ifdef ID_FWD_EN
    n_assert++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL fwd_ready: got %0h exp 1", if_ready_o); end
    tick();
    n_assert++; if (reg1_o !== 32'h0000000A) begin n_fail++; $display("FAIL fwd_prio: got %h exp 0000000a", reg1_o); end
    n_assert++; if ({reg2_o, wd_o} !== {32'h22222222, 5'd3}) begin n_fail++; $display("FAIL fwd_reg2: got %h wd=%0d", reg2_o, wd_o); end
`else
    n_assert++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL nofwd_stall0: got %0h exp 0", if_ready_o); end
    tick();
    n_assert++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL nofwd_bubble: got %0h exp 0", ex_valid_o); end
    fwd_wreg_i = 2'b10; #1;
    n_assert++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL nofwd_stall1: got %0h exp 0", if_ready_o); end
    tick();
    fwd_wreg_i = 2'b00; #1;
    n_assert++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL nofwd_release: got %0h exp 1", if_ready_o); end
    tick();
    n_assert++; if ({ex_valid_o, reg1_o, reg2_o} !== {1'b1, 32'h11111111, 32'h22222222}) begin n_fail++; $display("FAIL nofwd_issue: got v=%0h %h %h", ex_valid_o, reg1_o, reg2_o); end
`endif
    clear_fwd();
  endtask

  task automatic test_r0();
    reg1_data_i = 32'h77777777; reg2_data_i = 32'h33333333;
    if_valid_i = 1'b1; inst_i = I_OR0;
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd0}; fwd_wdata_i = {32'h0, 32'h00000055};
    #1;
    n_assert++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %0h exp 1", if_ready_o); end
    tick();
    n_assert++; if ({reg1_o, reg2_o} !== {32'h0, 32'h33333333}) begin n_fail++; $display("FAIL r0_ops: got %h %h exp 0 33333333", reg1_o, reg2_o); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    rst = 1'b1; if_valid_i = 1'b0; tick(); rst = 1'b0;
    reg1_data_i = 32'h44444444; reg2_data_i = 32'h0;
    if_valid_i = 1'b1; inst_i = I_ANDI;
    fwd_wreg_i = 2'b01; fwd_isload_i = 2'b01; fwd_wd_i = {5'd0, 5'd4}; fwd_wdata_i = {32'h0, 32'h0000DEAD};
    #1;
    n_assert++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL lu_ready0: got %0h exp 0", if_ready_o); end
    tick();
    n_assert++; if ({ex_valid_o, stall_cnt_o} !== {1'b0, 32'd1}) begin n_fail++; $display("FAIL lu_bubble1: got v=%0h cnt=%0d exp 0/1", ex_valid_o, stall_cnt_o); end
    n_assert++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL lu_ready1: got %0h exp 0", if_ready_o); end
    tick();
    n_assert++; if ({ex_valid_o, stall_cnt_o} !== {1'b0, 32'd2}) begin n_fail++; $display("FAIL lu_bubble2: got v=%0h cnt=%0d exp 0/2", ex_valid_o, stall_cnt_o); end
`ifdef ID_FWD_EN
    fwd_isload_i = 2'b00; fwd_wdata_i = {32'h0, 32'h00000077};
`else
    clear_fwd();
`endif
    #1;
    n_assert++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %0h exp 1", if_ready_o); end
    tick();
`ifdef ID_FWD_EN
    n_assert++; if (reg1_o !== 32'h00000077) begin n_fail++; $display("FAIL lu_reg1: got %h exp 00000077", reg1_o); end
`else
    n_assert++; if (reg1_o !== 32'h44444444) begin n_fail++; $display("FAIL lu_reg1: got %h exp 44444444", reg1_o); end
`endif
    n_assert++; if ({ex_valid_o, reg2_o, wd_o, aluop_o, stall_cnt_o} !== {1'b1, 32'h000000FF, 5'd5, 8'h24, 32'd2}) begin n_fail++; $display("FAIL lu_issue: got v=%0h r2=%h wd=%0d op=%0h cnt=%0d", ex_valid_o, reg2_o, wd_o, aluop_o, stall_cnt_o); end
    clear_fwd();
  endtask

  task automatic test_hold_reset();
    clear_fwd();
    ex_ready_i = 1'b1; if_valid_i = 1'b1; inst_i = I_ORI;
    reg1_data_i = 32'h12340000;
    tick();
    ex_ready_i = 1'b0; inst_i = I_LUI; reg1_data_i = 32'h99999999;
    #1;
    n_assert++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %0h exp 0", if_ready_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_assert++; if ({ex_valid_o, reg1_o, reg2_o, wd_o, aluop_o} !== {1'b1, 32'h12340000, 32'h000000F0, 5'd2, 8'h25}) begin n_fail++; $display("FAIL hold_stable%0d: got v=%0h %h %h wd=%0d op=%0h", i, ex_valid_o, reg1_o, reg2_o, wd_o, aluop_o); end
    end
    rst = 1'b1;
    tick();
    n_assert++; if ({ex_valid_o, reg1_o, reg2_o, wd_o, wreg_o, aluop_o, alusel_o, inst_invalid_o, stall_cnt_o} !== '0) begin n_fail++; $display("FAIL hold_rst: got v=%0h %h %h wd=%0d w=%0h op=%0h sel=%0h cnt=%0d", ex_valid_o, reg1_o, reg2_o, wd_o, wreg_o, aluop_o, alusel_o, stall_cnt_o); end
    n_assert++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_rst_ready: got %0h exp 0", if_ready_o); end
    rst = 1'b0; ex_ready_i = 1'b1;
  endtask

  task automatic test_invalid();
    clear_fwd();
    if_valid_i = 1'b1; inst_i = I_BAD;
    #1;
    n_assert++; if ({reg1_read_o, reg2_read_o} !== 2'b00) begin n_fail++; $display("FAIL inv_read: got %0b%0b exp 00", reg1_read_o, reg2_read_o); end
    tick();
    n_assert++; if ({ex_valid_o, inst_invalid_o, wreg_o, aluop_o} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin n_fail++; $display("FAIL inv_out: got v=%0h inv=%0h w=%0h op=%0h exp 1/1/0/0", ex_valid_o, inst_invalid_o, wreg_o, aluop_o); end
    if_valid_i = 1'b0;
    tick();
    n_assert++; if ({ex_valid_o, inst_invalid_o} !== 2'b00) begin n_fail++; $display("FAIL idle_bubble: got v=%0h inv=%0h exp 0/0", ex_valid_o, inst_invalid_o); end
  endtask

  initial begin
    test_reset();
    test_ori();
    test_back_to_back();
    test_fwd_priority();
    test_r0();
    test_load_use();
    test_hold_reset();
    test_invalid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_pipe.md
# id_pipe

Parametrised decode stage with a registered ID/EX output, N-source operand forwarding, and load-use interlock. It sits between the IF/ID register and the execute stage. It decodes the logic/shift subset of the ISA, selects operands from the register file, forwarding sources, or the immediate, and presents them through a valid/ready pipeline register. It stalls IF and inserts bubbles when a forwarded value is not yet available.

## Interface
- DATA_W, 32, operand/data width
- RA_W, 5, register address width
- NFWD, 2, number of forwarding sources; index 0 is youngest (EX), highest priority

- clk  in  1  clock
- rst  in  1  reset; rst: synchronous, active-high
- if_valid_i  in  1  inst_i/pc_i valid
- if_ready_o  out  1  stage accepts inst this cycle
- pc_i  in  32  instruction address
- inst_i  in  32  instruction word
- reg1_read_o / reg2_read_o  out  1  regfile read enables (combinational)
- reg1_addr_o / reg2_addr_o  out  RA_W  regfile read addresses, inst[25:21] / inst[20:16]
- reg1_data_i / reg2_data_i  in  DATA_W  regfile read data, same cycle
- fwd_wreg_i  in  NFWD  source k writes a register
- fwd_wd_i  in  NFWD*RA_W  destination of source k (slice k)
- fwd_wdata_i  in  NFWD*DATA_W  result of source k
- fwd_isload_i  in  NFWD  source k is a load; data not yet valid
- ex_valid_o  out  1  ID/EX register holds an instruction
- ex_ready_i  in  1  EX consumes ID/EX this cycle
- aluop_o  out  8  EXE_*_OP code
- alusel_o  out  3  EXE_RES_* code
- reg1_o / reg2_o  out  DATA_W  operands
- wd_o  out  RA_W  write destination
- wreg_o  out  1  write enable
- inst_invalid_o  out  1  undecodable instruction
- stall_cnt_o  out  32  saturating count of stall cycles

## Operation
- Decode (combinational):
  - ORI/ANDI/XORI: rs read, imm = zero-extended inst[15:0] to reg2, wd = inst[20:16], sel LOGIC.
  - LUI: rs not read, reg1 = 0, reg2 = {inst[15:0],16'h0}, aluop OR, wd = rt.
  - SPECIAL AND/OR/XOR/NOR: rs and rt read, wd = rd, sel LOGIC.
  - SPECIAL SLL/SRL/SRA: rt read, reg1 = zero-extended shamt inst[10:6], wd = rd, sel SHIFT.
  - All-zero word is a NOP: wreg = 0, valid, not invalid.
- Invalid opcode/funct: aluop NOP, wreg = 0, inst_invalid_o = 1, still passed downstream.
- Operand select, per read port: address 0 returns 0 and is never forwarded. Otherwise the lowest k with fwd_wreg_i[k] and matching fwd_wd supplies the value. With no match, regfile data is used. Unread ports take the immediate or shamt value as above.
- Hazard: a read port matches a source k (k is the first match) with fwd_isload_i[k] = 1. In that case:
  - if_ready_o = 0.
  - The bubble is loaded into ID/EX as ex_valid_o = 0 when it is accepted.
- stall_cnt_o increments on every cycle with if_valid_i and hazard. It saturates at 0xFFFFFFFF.

## Timing
- ID/EX loads when (!ex_valid_o || ex_ready_i):
  - With if_valid_i && !hazard, it loads the decoded instruction and sets ex_valid_o = 1.
  - Otherwise it loads a bubble.
- ID/EX holds when ex_valid_o && !ex_ready_i.
- if_ready_o = !hazard && (!ex_valid_o || ex_ready_i).
- Latency: one cycle, inst_i to ID/EX.
- Forwarding is sampled in the cycle the register loads. A held entry keeps its captured operands.
- Reset: on rst, all registered outputs clear to 0, including ex_valid_o, wreg_o, inst_invalid_o, stall_cnt_o, and aluop = EXE_NOP_OP. rst mid-stall drops the held instruction.
- While rst is high, if_ready_o = 0.

## Configuration
- ID_FWD_EN defined: forwarding as described.
- ID_FWD_EN undefined:
  - No forwarding muxes; operands always come from the regfile.
  - Any read-port match against any source k with fwd_wreg_i[k], load or not, is a hazard and stalls.
  - fwd_wdata_i is unused.

## Test plan
- ORI r2,r1,0x00F0 with reg1_data=0x12340000 and no forwarding -> next cycle: reg1_o=0x12340000, reg2_o=0x000000F0, wd_o=2, wreg_o=1, sel LOGIC.
- OR r3,r1,r2 with fwd0 (wd=1, data=0xA) and fwd1 (wd=1, data=0xB) -> reg1_o=0xA (priority). With ID_FWD_EN undefined -> stall until the sources clear.
- Read of r0 while fwd0 writes r0 with 0x55 -> reg1_o=0, no stall.
- ANDI reading r4 while fwd0 is a load to r4 for 2 cycles:
  - if_ready_o=0 for 2 cycles, 2 bubbles, stall_cnt_o=2.
  - Then the instruction issues with the forwarded value.
- ex_ready_i=0 for 3 cycles with a valid entry -> outputs stable, if_ready_o=0. Assert rst mid-hold -> all outputs 0 next cycle.
- inst 0xFC000000 -> ex_valid_o=1, inst_invalid_o=1, wreg_o=0.
